// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Request and instruction-memory bus bundle for the
//                instruction encoder. The slave modport is the encoder's
//                view; the master modport is the view of whoever issues
//                requests and services the memory writes.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_encoder_if;
  // session control and request handshake
  logic        start_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  op_sel_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [4:0]  shamt_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic        last_i;

  // instruction memory write port
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic        imem_ack_i;

  // session status
  logic [15:0] word_count_o;
  logic        err_o;
  logic        done_o;
  logic        full_o;

  modport slave (
    input  start_i, req_valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
           funct_i, imm_i, last_i, imem_ack_i,
    output req_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           word_count_o, err_o, done_o, full_o
  );

  modport master (
    output start_i, req_valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
           funct_i, imm_i, last_i, imem_ack_i,
    input  req_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           word_count_o, err_o, done_o, full_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs field-level instruction requests into 32-bit MIPS
//                words and writes them sequentially into instruction memory.
//                One request is accepted at a time; each valid request is
//                held on the memory port until acknowledged, then the word
//                address advances by 4. Invalid class codes are consumed
//                with a one-cycle error pulse and produce no write.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_encoder_if.slave  bus
);

  // class codes shared with the opcode decoder
  localparam logic [2:0] c_SEL_INV   = 3'b000;
  localparam logic [2:0] c_SEL_BNE   = 3'b001;
  localparam logic [2:0] c_SEL_RTYPE = 3'b010;
  localparam logic [2:0] c_SEL_BEQ   = 3'b011;
  localparam logic [2:0] c_SEL_ADDI  = 3'b100;
  localparam logic [2:0] c_SEL_LUI   = 3'b101;
  localparam logic [2:0] c_SEL_ORI   = 3'b110;
  localparam logic [2:0] c_SEL_SLTIU = 3'b111;

  // MIPS primary opcodes
  localparam logic [5:0] c_OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OPC_ADDI    = 6'b001000;
  localparam logic [5:0] c_OPC_BEQ     = 6'b000100;
  localparam logic [5:0] c_OPC_BNE     = 6'b000101;
  localparam logic [5:0] c_OPC_SLTIU   = 6'b001011;
  localparam logic [5:0] c_OPC_LUI     = 6'b001111;
  localparam logic [5:0] c_OPC_ORI     = 6'b001101;

  localparam logic [15:0] c_DEPTH    = 16'(DEPTH_WORDS);
  localparam logic [31:0] c_ADDR_INC = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        we_q;
  logic        err_q;
  logic        done_q;
  logic        last_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] count_q;

  // combinational encoding of the request currently on the bus
  logic [31:0] data_d;
  logic        op_ok_d;
  logic [15:0] count_d;

  // Encode the presented fields; lui ignores rs and always emits zero there.
  always_comb begin
    data_d  = 32'd0;
    op_ok_d = 1'b1;
    unique case (bus.op_sel_i)
      c_SEL_RTYPE: data_d = {c_OPC_SPECIAL, bus.rs_i, bus.rt_i, bus.rd_i,
                             bus.shamt_i, bus.funct_i};
      c_SEL_ADDI:  data_d = {c_OPC_ADDI,  bus.rs_i, bus.rt_i, bus.imm_i};
      c_SEL_BEQ:   data_d = {c_OPC_BEQ,   bus.rs_i, bus.rt_i, bus.imm_i};
      c_SEL_BNE:   data_d = {c_OPC_BNE,   bus.rs_i, bus.rt_i, bus.imm_i};
      c_SEL_SLTIU: data_d = {c_OPC_SLTIU, bus.rs_i, bus.rt_i, bus.imm_i};
      c_SEL_LUI:   data_d = {c_OPC_LUI,   5'b00000, bus.rt_i, bus.imm_i};
      c_SEL_ORI:   data_d = {c_OPC_ORI,   bus.rs_i, bus.rt_i, bus.imm_i};
      c_SEL_INV:   op_ok_d = 1'b0;
      default:     op_ok_d = 1'b0;
    endcase
  end

  // Word count after the pending write completes, used for the full check.
  always_comb begin
    count_d = count_q + 16'd1;
  end

  // Session FSM; every status output is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'd0;
      count_q <= 16'd0;
    end else begin
      // error is a single-cycle pulse unless re-armed below
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            state_q <= S_ACCEPT;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            count_q <= 16'd0;
            addr_q  <= BASE_ADDR;
          end
        end

        S_ACCEPT: begin
          // ready is always high here, so valid alone completes a transfer
          if (bus.req_valid_i) begin
            if (op_ok_d) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              data_q  <= data_d;
              last_q  <= bus.last_i;
            end else begin
              err_q <= 1'b1;
              if (bus.last_i) begin
                state_q <= S_DONE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end

        S_WRITE: begin
          // address and data stay frozen until the memory acknowledges
          if (bus.imem_ack_i) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + c_ADDR_INC;
            count_q <= count_d;
            if (last_q || (count_d == c_DEPTH)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ACCEPT;
              ready_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_data_o  = data_q;
  assign bus.word_count_o = count_q;
  assign bus.err_o        = err_q;
  assign bus.done_o       = done_q;
  assign bus.full_o       = (count_q == c_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. A deep instance and
//                a two-word instance see the same stimulus; sel picks which
//                one the checks observe. Expected words come from a field
//                arithmetic model with an opcode lookup table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

  localparam logic [31:0] c_BASE = 32'd0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encoder_if ifa ();
  instr_encoder_if ifb ();

  instr_encoder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(256)) u_big (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.slave)
  );

  instr_encoder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(2)) u_small (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.slave)
  );

  // the small instance mirrors every input of the big one
  assign ifb.start_i     = ifa.start_i;
  assign ifb.req_valid_i = ifa.req_valid_i;
  assign ifb.op_sel_i    = ifa.op_sel_i;
  assign ifb.rs_i        = ifa.rs_i;
  assign ifb.rt_i        = ifa.rt_i;
  assign ifb.rd_i        = ifa.rd_i;
  assign ifb.shamt_i     = ifa.shamt_i;
  assign ifb.funct_i     = ifa.funct_i;
  assign ifb.imm_i       = ifa.imm_i;
  assign ifb.last_i      = ifa.last_i;
  assign ifb.imem_ack_i  = ifa.imem_ack_i;

  // observed outputs of the instance under check
  bit          sel = 1'b0;
  logic        rdy, we, err, done, full;
  logic [31:0] addr, data;
  logic [15:0] cnt;

  always_comb begin
    rdy  = sel ? ifb.req_ready_o  : ifa.req_ready_o;
    we   = sel ? ifb.imem_we_o    : ifa.imem_we_o;
    err  = sel ? ifb.err_o        : ifa.err_o;
    done = sel ? ifb.done_o       : ifa.done_o;
    full = sel ? ifb.full_o       : ifa.full_o;
    addr = sel ? ifb.imem_addr_o  : ifa.imem_addr_o;
    data = sel ? ifb.imem_data_o  : ifa.imem_data_o;
    cnt  = sel ? ifb.word_count_o : ifa.word_count_o;
  end

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt;
  logic [31:0] exp_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;
  bit          session_over;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding: opcode table by class code, fields placed by weight.
  function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn,
                                          input logic [15:0] imm);
    logic [5:0]  opc [8];
    logic [31:0] w;
    opc = '{6'h00, 6'h05, 6'h00, 6'h04, 6'h08, 6'h0F, 6'h0D, 6'h0B};
    w = 32'(opc[op]) * 32'h0400_0000
      + 32'((op == 3'b101) ? 5'd0 : rs) * 32'h0020_0000
      + 32'(rt) * 32'h0001_0000;
    if (op == 3'b010) w = w + 32'(rd) * 32'h800 + 32'(sh) * 32'h40 + 32'(fn);
    else              w = w + 32'(imm);
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready", rdy, 1'b0);
    chk("rst_we",    we,   1'b0);
    chk("rst_err",   err,  1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_full",  full, 1'b0);
    chk("rst_addr",  addr, c_BASE);
    chk("rst_data",  data, 32'd0);
    chk("rst_cnt",   cnt,  16'd0);
  endtask

  task automatic start_session();
    ifa.start_i = 1'b1;
    @(posedge clk); #1;
    ifa.start_i = 1'b0;
    exp_cnt  = 16'd0;
    exp_addr = c_BASE;
    session_over = 1'b0;
    chk("start_ready", rdy,  1'b1);
    chk("start_cnt",   cnt,  16'd0);
    chk("start_addr",  addr, c_BASE);
    chk("start_done",  done, 1'b0);
    chk("start_full",  full, 1'b0);
  endtask

  // idle cycles in ACCEPT with random stray acks that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ifa.imem_ack_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle_ready", rdy, 1'b1);
      chk("idle_we",    we,  1'b0);
      chk("idle_cnt",   cnt, exp_cnt);
    end
    ifa.imem_ack_i = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic last, input int dly);
    logic [31:0] exp_w;
    int          depth;
    bit          fin;
    depth = sel ? 2 : 256;
    ifa.imem_ack_i = 1'b0;
    chk("ready_before", rdy, 1'b1);
    ifa.op_sel_i = op;  ifa.rs_i = rs;  ifa.rt_i = rt;  ifa.rd_i = rd;
    ifa.shamt_i = sh;   ifa.funct_i = fn; ifa.imm_i = imm; ifa.last_i = last;
    ifa.req_valid_i = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid_i = 1'b0;
    // scramble fields so a missing latch shows up as wrong data
    ifa.rs_i = 5'($urandom); ifa.rt_i = 5'($urandom); ifa.imm_i = 16'($urandom);
    ifa.last_i = 1'($urandom);
    if (op == 3'b000) begin
      chk("err_pulse",     err,  1'b1);
      chk("inv_no_we",     we,   1'b0);
      chk("inv_cnt",       cnt,  exp_cnt);
      chk("inv_done",      done, last);
      chk("inv_ready",     rdy,  !last);
      session_over = last;
      @(posedge clk); #1;
      chk("err_one_cycle", err,  1'b0);
    end else begin
      exp_w = ref_enc(op, rs, rt, rd, sh, fn, imm);
      chk("we_set",    we,   1'b1);
      chk("wr_addr",   addr, exp_addr);
      chk("wr_data",   data, exp_w);
      chk("ready_low", rdy,  1'b0);
      wr_data = data;
      wr_addr = addr;
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        chk("stall_we",    we,   1'b1);
        chk("stall_addr",  addr, exp_addr);
        chk("stall_data",  data, exp_w);
        chk("stall_ready", rdy,  1'b0);
        chk("stall_cnt",   cnt,  exp_cnt);
      end
      ifa.imem_ack_i = 1'b1;
      @(posedge clk); #1;
      ifa.imem_ack_i = 1'b0;
      exp_cnt  = exp_cnt + 16'd1;
      exp_addr = exp_addr + 32'd4;
      fin = last || (int'(exp_cnt) == depth);
      chk("we_drop",    we,   1'b0);
      chk("cnt",        cnt,  exp_cnt);
      chk("addr_next",  addr, exp_addr);
      chk("full",       full, int'(exp_cnt) == depth);
      chk("done",       done, fin);
      chk("ready_back", rdy,  !fin);
      session_over = fin;
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.start_i = 1'b0; ifa.req_valid_i = 1'b0; ifa.op_sel_i = 3'b000;
    ifa.rs_i = '0; ifa.rt_i = '0; ifa.rd_i = '0; ifa.shamt_i = '0;
    ifa.funct_i = '0; ifa.imm_i = '0; ifa.last_i = 1'b0; ifa.imem_ack_i = 1'b0;
    exp_cnt = '0; exp_addr = c_BASE; wr_data = '0; wr_addr = '0; session_over = 1'b1;

    do_reset();

    // addi $2,$1,5 as the only word of a session
    start_session();
    send(3'b100, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1, 0);
    chk("addi_word", wr_data, 32'h2022_0005);
    chk("addi_addr", wr_addr, 32'h0);

    // addu $3,$1,$2 then lui $4,0x1234 with last
    start_session();
    send(3'b010, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0000, 1'b0, 0);
    chk("addu_word", wr_data, 32'h0022_1821);
    send(3'b101, 5'd7, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b1, 0);
    chk("lui_word", wr_data, 32'h3C04_1234);
    chk("lui_addr", wr_addr, 32'h4);

    // ack stall of three cycles, then an invalid request between two valid ones
    start_session();
    send(3'b100, 5'd9, 5'd10, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b0, 3);
    send(3'b000, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h0001, 1'b0, 0);
    send(3'b110, 5'd3, 5'd5, 5'd0, 5'd0, 6'd0, 16'h00F0, 1'b0, 1);
    chk("after_inv_addr", wr_addr, 32'h4);
    send(3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 1'b1, 0);

    // randomized sessions against the reference model
    for (int k = 0; k < 60; k++) begin
      if (session_over) start_session();
      idle($urandom_range(0, 2));
      send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 6'($urandom), 16'($urandom),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // reset during a write stall
    if (session_over) start_session();
    ifa.op_sel_i = 3'b011; ifa.rs_i = 5'd4; ifa.rt_i = 5'd5; ifa.imm_i = 16'hFFFE;
    ifa.last_i = 1'b0; ifa.req_valid_i = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid_i = 1'b0;
    chk("pre_rst_we", we, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_stall", we, 1'b1);
    do_reset();
    ifa.op_sel_i = 3'b100; ifa.req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifa.imem_ack_i = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", rdy, 1'b0);
      chk("post_rst_we",    we,  1'b0);
      chk("post_rst_cnt",   cnt, 16'd0);
    end
    ifa.req_valid_i = 1'b0; ifa.imem_ack_i = 1'b0;
    start_session();
    send(3'b111, 5'd2, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b1, 0);
    chk("post_rst_addr", wr_addr, c_BASE);

    // full: two-word instance, three non-last requests
    sel = 1'b1;
    do_reset();
    start_session();
    send(3'b100, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 1'b0, 0);
    send(3'b110, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 1'b0, 1);
    chk("full_set", full, 1'b1);
    ifa.op_sel_i = 3'b001; ifa.last_i = 1'b0; ifa.req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("full_ready", rdy,  1'b0);
      chk("full_we",    we,   1'b0);
      chk("full_cnt",   cnt,  16'd2);
      chk("full_done",  done, 1'b1);
    end
    ifa.req_valid_i = 1'b0;
    start_session();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // absolute time bound so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader for the single-cycle MIPS core. It is the writer-side counterpart of the opcode decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each one into a 32-bit MIPS word using the same ALU-op class codes the decoder emits. It then writes the word into instruction memory through a write/ack handshake, advancing the word address, so a testbench or boot path can load programs that the CPU then fetches and decodes.

## Interface
- BASE_ADDR, 32'd0: byte address of the first written word.
- DEPTH_WORDS, 256: maximum words per load session, range 1..65535.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  begin a new load session (honoured in IDLE/DONE only)
- req_valid_i  input  1  request fields valid
- req_ready_o  output  1  encoder can accept a request
- op_sel_i  input  3  class code: 010 R-type, 100 addi, 011 beq, 001 bne, 111 sltiu, 101 lui, 110 ori; 000 invalid
- rs_i, rt_i, rd_i, shamt_i  input  5 each  register/shift fields
- funct_i  input  6  R-type function field
- imm_i  input  16  immediate/branch offset
- last_i  input  1  this request ends the session
- imem_we_o  output  1  write strobe, held until acknowledged
- imem_addr_o  output  32  byte address of the write
- imem_data_o  output  32  encoded instruction
- imem_ack_i  input  1  memory accepted the write this cycle
- word_count_o  output  16  words written this session
- err_o  output  1  one-cycle pulse: invalid op_sel consumed
- done_o  output  1  session finished (DONE state)
- full_o  output  1  word_count_o == DEPTH_WORDS

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE. Reset enters IDLE.
- IDLE/DONE with start_i=1: word_count := 0, imem_addr_o := BASE_ADDR, go to ACCEPT. In ACCEPT and WRITE, start_i is ignored.
- req_ready_o = 1 only in ACCEPT. A transfer occurs when valid&&ready at the clock edge; fields and last_i are latched.
- Encoding of a valid request (registered into imem_data_o):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - Others: {opcode, rs, rt, imm}, with opcodes addi 001000, beq 000100, bne 000101, sltiu 001011, lui 001111, ori 001101.
  - For lui, the rs field is forced to 00000.
- Valid request: go to WRITE.
- Invalid request (op_sel 000): err_o pulses for one cycle and no write is made; word_count is unchanged. Go to DONE if the latched last_i is set, otherwise stay in ACCEPT.
- WRITE: imem_we_o=1; imem_addr_o and imem_data_o are held stable until imem_ack_i=1 is sampled. On ack:
  - imem_addr_o += 4, wrapping modulo 2^32.
  - word_count += 1.
  - Go to DONE if last was latched or the new count == DEPTH_WORDS; otherwise go to ACCEPT.
- DONE: done_o=1 and req_ready_o=0 until start_i.
- full_o is combinational from word_count. Once full, no further request is accepted in the session.
- imem_ack_i is ignored outside WRITE.

## Timing
- Reset values: state IDLE; req_ready_o, imem_we_o, err_o, done_o, full_o all 0; imem_addr_o = BASE_ADDR; imem_data_o = 0; word_count_o = 0.
- Reset has priority over every event. Reset asserted in WRITE drops imem_we_o to 0 on the next cycle, and the pending word is discarded.
- Accept at edge N sets imem_we_o=1 during cycle N+1.
- With ack high in cycle N+1, the FSM is back in ACCEPT (ready=1) in cycle N+2.
- Sustained throughput: 1 word per 2 cycles. Each cycle of ack delay adds one cycle.
- err_o is high for exactly the cycle after the edge that consumed the invalid request.
- done_o rises the cycle after the final ack edge, or after the final invalid consume.
- start_i sampled in DONE gives req_ready_o=1 in the next cycle.

## Test plan
- **addi:** After start, send op 100, rs=1, rt=2, imm=0x0005 with ack immediate. Required: a single write of 0x20220005 to address 0x0; word_count=1; ready returns 2 cycles after accept.
- **addu then lui, last on lui:** Send R-type rs=1, rt=2, rd=3, shamt=0, funct=0x21, then lui rs_i=7, rt=4, imm=0x1234 with last. Required: 0x00221821 at address 0x0 and 0x3C041234 at address 0x4; done_o=1; count=2.
- **Ack stall:** Hold imem_ack_i low for 3 cycles during WRITE. Required: we, addr and data stable throughout; req_ready_o=0; exactly one count increment after ack.
- **Full:** With DEPTH_WORDS=2, send 3 non-last requests. Required: two writes, full_o=1, done_o=1; the third request is never accepted.
- **Invalid op:** Send op_sel 000 between two valid ops. Required: err_o high for one cycle; no write; addresses 0x0 and 0x4 remain contiguous.
- **Reset mid-operation:** Assert rst_i during a WRITE stall. Required: we low next cycle, all outputs at their reset values, state IDLE; start_i is required before any further acceptance.
